sub_pipe8: RTL and testbench
============================

// Module: sub_pipe8
// PURPOSE
//  Two-stage pipelined subtractor: diff = a - b - bin, with borrow-out and signed overflow.
//  Companion to the combinational carry-lookahead adder. Serves the Goldschmidt datapath's
//  "2 - x" correction term and remainder checks.
//  Low half is resolved in stage 1 and high half in stage 2, giving a short critical path.
//  Valid/ready streaming on both sides: full throughput, full backpressure.
// PARAMETERS
//  WIDTH  8  operand width; must be even; HW = WIDTH/2 bits are processed per stage
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//  bout       out  1      unsigned borrow: 1 iff a < b + bin
//  ovf        out  1      signed overflow: a[W-1]!=b[W-1] && diff[W-1]!=a[W-1]
//  sat        out  1      saturation flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, rst_n=0): s1_valid=0, s2_valid=0; in_ready=1 is combinational;
//    out_valid=0; diff=0, bout=0, ovf=0, sat=0. All pipeline data registers clear to 0.
//  - Transfers occur only on rising clk when valid&&ready are both 1 on that side.
//  - Stage 1 (on input accept):
//    - {lb, s1_lo} = a[HW-1:0] - b[HW-1:0] - bin; lb is the low-half borrow.
//    - Registers s1_lo, lb, a_hi, b_hi and sets s1_valid.
//  - Stage 2 (on s1 -> s2 advance):
//    - {hb, hi} = a_hi - b_hi - lb.
//    - Registers diff={hi,s1_lo}, bout=hb and ovf; sets s2_valid.
//  - out_valid = s2_valid; outputs are taken directly from registers.
//  - Advance rules:
//    - s2 loads when s1_valid && (!s2_valid || out_ready).
//    - in_ready = !s1_valid || s2 loads this cycle.
//    - s1 clears when it advances and no new input is accepted in the same cycle.
//  - Latency: 2 cycles from input accept to out_valid when there is no stall.
//    Throughput: 1 result/cycle while out_ready=1.
//  - Stall: out_valid=1 && out_ready=0 holds diff/bout/ovf/sat stable. s1 keeps its data.
//    in_ready drops once s1 is occupied. No result is lost or duplicated.
//  - Simultaneous events: output pop, s1->s2 advance and input accept can all occur in
//    one cycle; the pipeline stays full.
//  - Bubble collapse: an empty s2 is filled from s1 even when out_ready=0.
//  - Outputs emerge in strict input order.
//  - Reset mid-operation discards in-flight data; no out_valid appears afterwards
//    until a new input is accepted.
//  - Wrap-around: bin=1 with a=b gives diff=all-ones and bout=1.
// CONFIGURATION
//  SUB_PIPE_SAT_EN defined:
//    - When bout=1, stage 2 registers diff=0 and sat=1 (unsigned floor).
//    - ovf is still computed from the unclamped result.
//  SUB_PIPE_SAT_EN undefined:
//    - diff wraps modulo 2^WIDTH; sat is tied to 0. Port list is identical in both builds.
// TESTING
//  - Basic: a=0x5A, b=0x23, bin=0 -> 2 cycles later diff=0x37, bout=0, ovf=0.
//  - Cross-nibble borrow: a=0x10, b=0x01, bin=1 -> diff=0x0E, bout=0.
//    Confirms the low borrow propagates into stage 2.
//  - Underflow: a=0x00, b=0x01, bin=0.
//    Without macro -> diff=0xFF, bout=1, sat=0. With macro -> diff=0x00, bout=1, sat=1.
//  - Signed overflow: a=0x80, b=0x01 -> diff=0x7F, ovf=1, bout=0.
//  - Backpressure: stream 4 vectors with out_ready=0 for 5 cycles, then 1.
//    -> in_ready=0 after 2 accepts; all 4 results arrive in order, none dropped or repeated.
//  - Reset mid-stream: assert rst_n=0 with 2 items in flight.
//    -> out_valid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/sub_pipe8.sv
// ---------------------------------------------------------------------------
// sub_pipe8 : two-stage valid/ready subtractor, diff = a - b - bin.
// Optional SUB_PIPE_SAT_EN clamps underflow to zero.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sub_pipe8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             sat
);

  localparam int c_HW = WIDTH / 2;

  logic            r_s1_valid;
  logic [c_HW-1:0] r_s1_lo;
  logic            r_s1_lb;
  logic [c_HW-1:0] r_s1_a_hi;
  logic [c_HW-1:0] r_s1_b_hi;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_sat;

  logic             w_s2_load;
  logic             w_accept;
  logic [c_HW:0]    w_lo_full;
  logic [c_HW:0]    w_hi_full;
  logic [WIDTH-1:0] w_diff;
  logic             w_ovf;
  logic             w_sat;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_accept  = in_valid && in_ready;

  // The extra MSB of each half-width difference is that half's borrow.
  assign w_lo_full = {1'b0, a[c_HW-1:0]} - {1'b0, b[c_HW-1:0]} - {{c_HW{1'b0}}, bin};
  assign w_hi_full = {1'b0, r_s1_a_hi} - {1'b0, r_s1_b_hi} - {{c_HW{1'b0}}, r_s1_lb};

  always_comb begin
    w_ovf = (r_s1_a_hi[c_HW-1] != r_s1_b_hi[c_HW-1]) &&
            (w_hi_full[c_HW-1] != r_s1_a_hi[c_HW-1]);
`ifdef SUB_PIPE_SAT_EN
    w_diff = w_hi_full[c_HW] ? '0 : {w_hi_full[c_HW-1:0], r_s1_lo};
    w_sat  = w_hi_full[c_HW];
`else
    w_diff = {w_hi_full[c_HW-1:0], r_s1_lo};
    w_sat  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_lb    <= 1'b0;
      r_s1_a_hi  <= '0;
      r_s1_b_hi  <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_lo    <= w_lo_full[c_HW-1:0];
      r_s1_lb    <= w_lo_full[c_HW];
      r_s1_a_hi  <= a[WIDTH-1:c_HW];
      r_s1_b_hi  <= b[WIDTH-1:c_HW];
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
      r_bout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_sat      <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_diff     <= w_diff;
      r_bout     <= w_hi_full[c_HW];
      r_ovf      <= w_ovf;
      r_sat      <= w_sat;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign sat       = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_sub_pipe8.sv
// ---------------------------------------------------------------------------
// Module : tb_sub_pipe8
// Brief  : directed and random stream checks against an arithmetic model.
// Rev    : 1.1
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sub_pipe8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
    logic       sat;

    sub_pipe8 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       ov;
        logic       sa;
        int         t;
    } item_t;

    item_t q[$];
    int tot = 0;
    int bad = 0;
    int cyc = 0;
    bit popped;
    int pop_cyc;
    int acc_cyc;
    int acc_count;
    logic [7:0] got_d;
    logic got_bo, got_ov, got_sa;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tot++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic item_t model(input logic [7:0] x, input logic [7:0] y, input logic c);
        item_t r;
        int full;
        full = int'(x) - int'(y) - int'(c);
        r.bo = (full < 0);
        r.d  = full[7:0];
        r.ov = (x[7] != y[7]) && (r.d[7] != x[7]);
        r.sa = 1'b0;
`ifdef SUB_PIPE_SAT_EN
        if (r.bo) begin
            r.d  = 8'h00;
            r.sa = 1'b1;
        end
`endif
        r.t = 0;
        return r;
    endfunction

    task automatic step();
        bit exp_ir, exp_ov;
        item_t it;
        #1;
        exp_ir = (q.size() < 2) || out_ready;
        exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
        check("in_ready", in_ready, exp_ir);
        check("out_valid", out_valid, exp_ov);
        popped = 1'b0;
        if (exp_ov) begin
            check("diff", diff, q[0].d);
            check("bout", bout, q[0].bo);
            check("ovf", ovf, q[0].ov);
            check("sat", sat, q[0].sa);
            if (out_ready) begin
                popped = 1'b1;
                pop_cyc = cyc;
                got_d = diff; got_bo = bout; got_ov = ovf; got_sa = sat;
                void'(q.pop_front());
            end
        end
        if (in_valid && exp_ir) begin
            it = model(a, b, bin);
            it.t = cyc;
            acc_cyc = cyc;
            acc_count++;
            q.push_back(it);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_vec(input logic [7:0] x, input logic [7:0] y, input logic c,
                           input logic [7:0] ed, input logic eb, input logic eo, input logic es,
                           input string tag);
        bit done;
        a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            step();
            if (popped) done = 1'b1;
        end
        if (!done) begin
            check({tag, "_timeout"}, 1'b0, 1'b1);
        end else begin
            check({tag, "_lat"}, pop_cyc - acc_cyc, 2);
            check({tag, "_diff"}, got_d, ed);
            check({tag, "_bout"}, got_bo, eb);
            check({tag, "_ovf"}, got_ov, eo);
            check({tag, "_sat"}, got_sa, es);
        end
    endtask

    initial begin
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_diff", diff, 8'h00);
        check("rst_flags", {bout, ovf, sat}, 3'b000);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 1'b0, "basic");
        run_vec(8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0, 1'b0, "xnib");
`ifdef SUB_PIPE_SAT_EN
        run_vec(8'h00, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "under");
        run_vec(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, "wrap");
`else
        run_vec(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, "under");
        run_vec(8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, "wrap");
`endif
        run_vec(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, "sovf");

        acc_count = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'h40 + 8'(acc_count); b = 8'h11; bin = acc_count[0];
            step();
        end
        check("bp_accepts", acc_count, 2);
        check("bp_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 12 && (acc_count < 4 || q.size() > 0); i++) begin
            in_valid = (acc_count < 4);
            a = 8'h40 + 8'(acc_count); b = 8'h11; bin = acc_count[0];
            step();
        end
        in_valid = 1'b0;
        check("bp_total", acc_count, 4);
        check("bp_drained", q.size(), 0);

        in_valid = 1'b1; out_ready = 1'b0;
        a = 8'hC3; b = 8'h21; bin = 1'b0;
        step();
        a = 8'h77; b = 8'h99; bin = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_in_ready", in_ready, 1'b1);
        check("mrst_diff", diff, 8'h00);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || popped || (q.size() > 0 && q[$].t == cyc - 1)) begin
                a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            end
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        check("rand_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule

`default_nettype wire
